// File: rtl/macc_ctrl_pkg.sv
// Shared constants and types for the MACC dot-product sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package macc_ctrl_pkg;

  // MACC datapath widths
  localparam int MACC_OP_W  = 32;
  localparam int MACC_RES_W = 64;

  // Sequencer state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // One operand pair as presented to the MACC
  typedef struct packed {
    logic [MACC_OP_W-1:0] a;
    logic [MACC_OP_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/macc_dot_sequencer_if.sv
// Bundle of job, operand, MACC and result signals around the dot-product sequencer.
// Latency: n/a (wiring only).
// Backpressure: operand port uses in_valid/in_ready, result port uses out_valid/out_ready.
interface macc_dot_sequencer_if #(
  parameter int LEN_W = 16
);
  import macc_ctrl_pkg::*;

  // job control
  logic                  start;
  logic [LEN_W-1:0]      cfg_len;
  logic                  busy;
  // operand stream
  logic                  in_valid;
  logic                  in_ready;
  logic [MACC_OP_W-1:0]  in_a;
  logic [MACC_OP_W-1:0]  in_b;
  // MACC side
  logic [MACC_OP_W-1:0]  macc_a;
  logic [MACC_OP_W-1:0]  macc_b;
  logic                  macc_ae;
  logic [MACC_RES_W-1:0] macc_result;
  // result port
  logic                  out_valid;
  logic                  out_ready;
  logic [MACC_RES_W-1:0] out_data;

  // environment view: fetch logic, MACC and result consumer
  modport master (
    output start, cfg_len, in_valid, in_a, in_b, macc_result, out_ready,
    input  busy, in_ready, macc_a, macc_b, macc_ae, out_valid, out_data
  );

  // sequencer view
  modport slave (
    input  start, cfg_len, in_valid, in_a, in_b, macc_result, out_ready,
    output busy, in_ready, macc_a, macc_b, macc_ae, out_valid, out_data
  );

endinterface

// File: rtl/macc_seq_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, never wraps below zero.
// Latency: count updates one clk edge after load/dec.
// Backpressure: none.
module macc_seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // load has priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/macc_dot_sequencer.sv
// Streams N operand pairs into an external MACC and returns the 64-bit dot product.
// Latency: result valid MACC_LAT+1 edges after the last pair is accepted.
// Backpressure: in_ready only in STREAM; result held in DONE until out_ready.
module macc_dot_sequencer
  import macc_ctrl_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int MACC_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  macc_dot_sequencer_if.slave bus
);

  logic [1:0]            state;
  logic                  first;
  pair_t                 feed_q;
  logic                  ae_q;
  logic [MACC_RES_W-1:0] data_q;

  // shared counter: remaining pairs during STREAM, then MACC drain edges during DRAIN
  logic                  cnt_load;
  logic [LEN_W-1:0]      cnt_val;
  logic                  cnt_dec;
  logic [LEN_W-1:0]      cnt;
  logic                  cnt_zero;

  logic                  in_hs;
  logic                  last_pair;

  assign in_hs     = bus.in_valid && (state == ST_STREAM);
  assign last_pair = (cnt == LEN_W'(1));

  macc_seq_counter #(.W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // counter control: load job length on start, reload drain count on the last pair
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && (bus.cfg_len != '0)) begin
          cnt_load = 1'b1;
          cnt_val  = bus.cfg_len;
        end
      end
      ST_STREAM: begin
        if (in_hs) begin
          if (last_pair) begin
            cnt_load = 1'b1;
            cnt_val  = LEN_W'(MACC_LAT);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_DRAIN: cnt_dec = !cnt_zero;
      default: ;
    endcase
  end

  // job FSM and first-pair tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.cfg_len != '0) begin
              state <= ST_STREAM;
              first <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_STREAM: begin
          if (in_hs) begin
            first <= 1'b0;
            if (last_pair) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_zero) state <= ST_DONE;
        end
        ST_DONE: begin
          // start in the same cycle as out_ready is deliberately dropped
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MACC feed: real pair on a handshake (first one restarts the sum), otherwise add 0*0
  always_ff @(posedge clk) begin
    if (!rst) begin
      feed_q <= '0;
      ae_q   <= 1'b0;
    end else if (in_hs) begin
      feed_q <= '{a: bus.in_a, b: bus.in_b};
      ae_q   <= !first;
    end else begin
      feed_q <= '0;
      ae_q   <= 1'b1;
    end
  end

  // result capture: MACC output once drained, or zero for an empty job
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if ((state == ST_IDLE) && bus.start && (bus.cfg_len == '0)) begin
      data_q <= '0;
    end else if ((state == ST_DRAIN) && cnt_zero) begin
      data_q <= bus.macc_result;
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.in_ready  = (state == ST_STREAM);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_data  = data_q;
  assign bus.macc_a    = feed_q.a;
  assign bus.macc_b    = feed_q.b;
  assign bus.macc_ae   = ae_q;

endmodule
